// File: rtl/kyber_pkg.sv
// Shared ML-KEM constants and the ByteDecode12 sequencer types.
// Imported by the key-decode control path and its unpack datapath.
package kyber_pkg;

  localparam int KYBER_N        = 256;
  localparam int KYBER_Q        = 3329;
  localparam int POLYBYTES      = 384;
  localparam int PAIRS_PER_POLY = KYBER_N / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPT,
    ST_EMIT,
    ST_DONE
  } dec_state_e;

  typedef struct packed {
    logic [11:0] c0;
    logic [11:0] c1;
  } coef_pair_t;

endpackage

// File: rtl/ek_decode12_ctrl_if.sv
// Byte-buffer read port and coefficient-pair stream of the ByteDecode12 sequencer.
// MODULUS_CHECK_EN adds the coef_err / key_invalid sideband.
interface ek_decode12_ctrl_if #(
  parameter int ADDR_W = 11
);

  logic              byte_rd_en;
  logic [ADDR_W-1:0] byte_addr;
  logic [7:0]        byte_data;

  logic              coef_valid;
  logic              coef_ready;
  logic [11:0]       coef_0;
  logic [11:0]       coef_1;
  logic [1:0]        coef_poly;
  logic [6:0]        coef_idx;

`ifdef MODULUS_CHECK_EN
  logic              coef_err;
  logic              key_invalid;

  modport master (
    output byte_rd_en, byte_addr, coef_valid, coef_0, coef_1, coef_poly, coef_idx,
           coef_err, key_invalid,
    input  byte_data, coef_ready
  );

  modport slave (
    input  byte_rd_en, byte_addr, coef_valid, coef_0, coef_1, coef_poly, coef_idx,
           coef_err, key_invalid,
    output byte_data, coef_ready
  );
`else
  modport master (
    output byte_rd_en, byte_addr, coef_valid, coef_0, coef_1, coef_poly, coef_idx,
    input  byte_data, coef_ready
  );

  modport slave (
    input  byte_rd_en, byte_addr, coef_valid, coef_0, coef_1, coef_poly, coef_idx,
    output byte_data, coef_ready
  );
`endif

endinterface

// File: rtl/bytes3_to_coef12.sv
// Combinational ByteDecode12 unpack: three little-endian bytes -> two 12-bit coefficients.
module bytes3_to_coef12
  import kyber_pkg::*;
(
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  output coef_pair_t pair
);

  assign pair.c0 = {b1[3:0], b0};
  assign pair.c1 = {b2, b1[7:4]};

endmodule

// File: rtl/ek_decode12_ctrl.sv
// ByteDecode12 sequencer: reads 384*K key bytes and streams tagged 12-bit coefficient pairs.
// Optional MODULUS_CHECK_EN: flags pairs with a coefficient >= Q and keeps a sticky key_invalid.
module ek_decode12_ctrl
  import kyber_pkg::*;
#(
  parameter int K      = 3,
  parameter int ADDR_W = 11
`ifdef MODULUS_CHECK_EN
  ,
  parameter int Q      = KYBER_Q
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  ek_decode12_ctrl_if.master  bus
);

  dec_state_e        state_q, state_d;
  logic [1:0]        sub_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [1:0]        poly_q;
  logic [6:0]        idx_q;
  logic [7:0]        b0_q, b1_q;
  coef_pair_t        pair_q, pair_w;

  logic rd_en;
  logic coef_valid;
  logic handshake;
  logic last_pair;

  // Third byte arrives on byte_data during CAPT and goes straight into the pair register.
  bytes3_to_coef12 u_unpack (
    .b0   (b0_q),
    .b1   (b1_q),
    .b2   (bus.byte_data),
    .pair (pair_w)
  );

  assign last_pair = (idx_q == 7'(PAIRS_PER_POLY - 1)) && (poly_q == 2'(K - 1));
  assign handshake = coef_valid && bus.coef_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    coef_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (sub_q == 2'd2) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        busy    = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        busy       = 1'b1;
        coef_valid = 1'b1;
        if (handshake) state_d = last_pair ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: clocked state is updated with non-blocking assignments so every register sees pre-edge values.
      sub_q  <= 2'd0;
      ptr_q  <= '0;
      poly_q <= 2'd0;
      idx_q  <= 7'd0;
      b0_q   <= 8'd0;
      b1_q   <= 8'd0;
      pair_q <= '0;
    end else if (!abort) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sub_q  <= 2'd0;
            ptr_q  <= '0;
            poly_q <= 2'd0;
            idx_q  <= 7'd0;
          end
        end
        ST_FETCH: begin
          ptr_q <= ptr_q + 1'b1;
          sub_q <= (sub_q == 2'd2) ? 2'd0 : sub_q + 2'd1;
          if (sub_q == 2'd1) b0_q <= bus.byte_data;
          if (sub_q == 2'd2) b1_q <= bus.byte_data;
        end
        ST_CAPT: begin
          pair_q <= pair_w;
        end
        ST_EMIT: begin
          if (handshake && !last_pair) begin
            idx_q <= idx_q + 7'd1;
            if (idx_q == 7'(PAIRS_PER_POLY - 1)) poly_q <= poly_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_rd_en = rd_en;
  assign bus.byte_addr  = rd_en ? ptr_q : '0;
  assign bus.coef_valid = coef_valid;
  assign bus.coef_0     = pair_q.c0;
  assign bus.coef_1     = pair_q.c1;
  assign bus.coef_poly  = poly_q;
  assign bus.coef_idx   = idx_q;

`ifdef MODULUS_CHECK_EN
  localparam logic [11:0] Q12 = 12'(Q);

  logic coef_err;
  logic key_invalid_q;

  assign coef_err = coef_valid && ((pair_q.c0 >= Q12) || (pair_q.c1 >= Q12));

  // Sticky over a whole key; only a freshly accepted start clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_invalid_q <= 1'b0;
    end else if (!abort) begin
      if (state_q == ST_IDLE && start) key_invalid_q <= 1'b0;
      else if (handshake && coef_err)  key_invalid_q <= 1'b1;
    end
  end

  assign bus.coef_err    = coef_err;
  assign bus.key_invalid = key_invalid_q;
`endif

endmodule

// File: tb/tb_ek_decode12_ctrl.sv
// Randomized self-checking bench for ek_decode12_ctrl (K=2) against a 24-bit-word decode model.
// Covers MODULUS_CHECK_EN outputs when that macro is defined.
module tb_ek_decode12_ctrl;
  import kyber_pkg::*;

  localparam int K      = 2;
  localparam int ADDR_W = 11;
  localparam int NPAIRS = K * KYBER_N / 2;
  localparam int NBYTES = K * POLYBYTES;

  typedef struct {
    int c0;
    int c1;
    int poly;
    int idx;
  } exp_pair_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic abort   = 1'b0;
  logic busy;
  logic done;

  ek_decode12_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  ek_decode12_ctrl #(.K(K), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key byte buffer with one-cycle read latency; garbage when no read is issued.
  logic [7:0] mem [0:2047];

  always @(posedge clk) begin
    if (bus.byte_rd_en) bus.byte_data <= mem[bus.byte_addr];
    else                bus.byte_data <= 8'($urandom);
  end

  // Reference: each 3-byte group is a little-endian 24-bit word split into two 12-bit halves.
  function automatic exp_pair_t model_pair(input int p, input int i);
    exp_pair_t r;
    int base, word;
    base   = POLYBYTES * p + 3 * i;
    word   = int'(mem[base]) | (int'(mem[base + 1]) << 8) | (int'(mem[base + 2]) << 16);
    r.c0   = word & 'hFFF;
    r.c1   = (word >> 12) & 'hFFF;
    r.poly = p;
    r.idx  = i;
    return r;
  endfunction

  // Compare-process state (written only by the compare process).
  exp_pair_t exp_q[$];
  exp_pair_t e;
  bit run_active = 0;
  bit done_seen  = 0;
  int pair_no    = 0;
  int stalls     = 0;
  int cyc        = 0;
  int exp_addr   = 0;
  int last_addr  = -1;
  int done_cnt   = 0;
  int done_at    = -1;
  int got_c0 [0:1023];
  int got_c1 [0:1023];
`ifdef MODULUS_CHECK_EN
  bit any_flag = 0;
  bit flag;
  int got_err [0:1023];
`endif

  always @(negedge clk) begin
    if (!reset_n) begin
      run_active = 0;
    end else begin
      if (abort) begin
        run_active = 0;
      end else if (start && !run_active) begin
        exp_q.delete();
        for (int p = 0; p < K; p++)
          for (int i = 0; i < KYBER_N / 2; i++) exp_q.push_back(model_pair(p, i));
        pair_no    = 0;
        stalls     = 0;
        cyc        = 0;
        exp_addr   = 0;
        done_seen  = 0;
        run_active = 1;
`ifdef MODULUS_CHECK_EN
        any_flag   = 0;
`endif
      end

      if (done && !run_active) check("spurious_done", done, 1'b0);

      if (run_active) begin
        check("busy", busy, (cyc >= 1) && !done);
        if (bus.byte_rd_en) begin
          check("byte_addr", bus.byte_addr, exp_addr);
          last_addr = int'(bus.byte_addr);
          exp_addr++;
        end
        if (bus.coef_valid) begin
          check("rd_en_during_emit", bus.byte_rd_en, 1'b0);
          if (exp_q.size() == 0) begin
            check("unexpected_pair", bus.coef_valid, 1'b0);
          end else begin
            e = exp_q[0];
            check("coef_0", bus.coef_0, e.c0);
            check("coef_1", bus.coef_1, e.c1);
            check("coef_poly", bus.coef_poly, e.poly);
            check("coef_idx", bus.coef_idx, e.idx);
`ifdef MODULUS_CHECK_EN
            flag = (e.c0 >= KYBER_Q) || (e.c1 >= KYBER_Q);
            check("coef_err", bus.coef_err, flag);
            check("key_invalid", bus.key_invalid, any_flag);
`endif
            if (bus.coef_ready) begin
              got_c0[pair_no] = int'(bus.coef_0);
              got_c1[pair_no] = int'(bus.coef_1);
`ifdef MODULUS_CHECK_EN
              got_err[pair_no] = int'(bus.coef_err);
              any_flag = any_flag | flag;
`endif
              void'(exp_q.pop_front());
              pair_no++;
            end else begin
              stalls++;
            end
          end
        end
        if (done) begin
          check("pairs_left_at_done", exp_q.size(), 0);
          check("done_cycle", cyc, 1 + 5 * NPAIRS + stalls);
          done_at    = cyc;
          done_seen  = 1;
          run_active = 0;
        end
        cyc++;
      end
      if (done) done_cnt++;
    end
  end

  // Sink: always ready, or random with pair 5 held off for 7 valid cycles.
  int ready_mode = 0;
  int stall_cnt  = 0;

  initial begin
    bus.coef_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pair_no < 5) stall_cnt = 0;
      if (ready_mode == 0) begin
        bus.coef_ready = 1'b1;
      end else if (pair_no == 5 && stall_cnt < 7) begin
        bus.coef_ready = 1'b0;
        if (bus.coef_valid) stall_cnt++;
      end else begin
        bus.coef_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic fill_pattern(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int i = 0; i < NBYTES; i += 3) begin
      mem[i]     = a;
      mem[i + 1] = b;
      mem[i + 2] = c;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit extra_starts);
    for (int n = 0; n < 6000 && !done_seen; n++) begin
      @(posedge clk);
      #1;
      start = extra_starts && (pair_no == 10 || pair_no == 100) && (n % 2 == 0);
    end
    start = 1'b0;
    check("done_reached", done_seen, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},       busy,           1'b0);
    check({tag, "_done"},       done,           1'b0);
    check({tag, "_byte_rd_en"}, bus.byte_rd_en, 1'b0);
    check({tag, "_byte_addr"},  bus.byte_addr,  '0);
    check({tag, "_coef_valid"}, bus.coef_valid, 1'b0);
    check({tag, "_coef_0"},     bus.coef_0,     '0);
    check({tag, "_coef_1"},     bus.coef_1,     '0);
    check({tag, "_coef_poly"},  bus.coef_poly,  '0);
    check({tag, "_coef_idx"},   bus.coef_idx,   '0);
`ifdef MODULUS_CHECK_EN
    check({tag, "_key_invalid"}, bus.key_invalid, 1'b0);
`endif
  endtask

  task automatic check_run_end(input string tag, input int done_base);
    check({tag, "_done_count"}, done_cnt - done_base, 1);
    check({tag, "_pair_count"}, pair_no, NPAIRS);
    check({tag, "_last_addr"},  last_addr, NBYTES - 1);
  endtask

  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fixed triple, sink always ready: exact latency and literal pair values.
    fill_pattern(8'h01, 8'h23, 8'h45);
    ready_mode = 0;
    base = done_cnt;
    pulse_start();
    wait_done(1'b0);
    check_run_end("pattern", base);
    check("pattern_done_at", done_at, 1281);
    check("pattern_first_c0", got_c0[0], 'h301);
    check("pattern_first_c1", got_c1[0], 'h452);
    check("pattern_last_c1", got_c1[NPAIRS - 1], 'h452);

    // Random bytes, random backpressure with a long stall on pair 5, extra starts while busy.
    fill_random();
    ready_mode = 1;
    base = done_cnt;
    pulse_start();
    wait_done(1'b1);
    check_run_end("random_bp", base);

    // start together with abort: abort wins, nothing begins.
    @(posedge clk);
    #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    check("start_with_abort_busy", busy, 1'b0);
    @(posedge clk);
    #1 check("start_with_abort_rd_en", bus.byte_rd_en, 1'b0);

    // Abort at pair 40, then a fresh run from address 0.
    fill_random();
    ready_mode = 0;
    base = done_cnt;
    pulse_start();
    for (int n = 0; n < 2000 && pair_no != 40; n++) begin
      @(posedge clk);
      #1;
    end
    check("abort_reached_pair_40", pair_no, 40);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_rd_en", bus.byte_rd_en, 1'b0);
    check("abort_coef_valid", bus.coef_valid, 1'b0);
    repeat (20) @(posedge clk);
    #1 check("abort_no_done", done_cnt - base, 0);
    fill_random();
    ready_mode = 1;
    base = done_cnt;
    pulse_start();
    wait_done(1'b0);
    check_run_end("after_abort", base);

    // Asynchronous reset in the middle of a FETCH.
    fill_random();
    ready_mode = 0;
    base = done_cnt;
    pulse_start();
    for (int n = 0; n < 200 && !(pair_no == 3 && bus.byte_rd_en); n++) begin
      @(posedge clk);
      #1;
    end
    check("reset_reached_fetch", bus.byte_rd_en, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("midreset_no_done", done_cnt - base, 0);
    base = done_cnt;
    pulse_start();
    wait_done(1'b0);
    check_run_end("after_reset", base);

    // Out-of-range and boundary triples at the front of a random key.
    fill_random();
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'hFF;
    mem[3] = 8'h00; mem[4] = 8'h0D; mem[5] = 8'h00;
    ready_mode = 1;
    base = done_cnt;
    pulse_start();
    wait_done(1'b0);
    check_run_end("modulus", base);
    check("ff_c0", got_c0[0], 'hFFF);
    check("ff_c1", got_c1[0], 'hFFF);
    check("q_minus_1_c0", got_c0[1], 3328);
    check("q_minus_1_c1", got_c1[1], 0);
`ifdef MODULUS_CHECK_EN
    check("ff_coef_err", got_err[0], 1);
    check("q_minus_1_coef_err", got_err[1], 0);
    check("key_invalid_sticky", bus.key_invalid, 1'b1);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
